// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock)
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_start    conversion request, sampled only while o_busy=0
//   i_value    8-bit operand, captured on the edge that accepts i_start
//   o_busy     high while the 8 shift iterations run
//   o_done     one-cycle pulse when new digits are valid
//   o_hund     hundreds digit (0..2)
//   o_tens     tens digit (0..9)
//   o_unit     units digit (0..9)
//   o_blank_h  leading-zero blank for the hundreds display
//   o_blank_t  leading-zero blank for the tens display
//   o_sign     negative flag (only driven when SIGNED_EN is defined, else 0)
//
// Build option: define SIGNED_EN to treat i_value as two's complement and
// convert its magnitude, reporting the sign on o_sign.
module bin_to_bcd_seq (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_value,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_hund,
    output logic [3:0] o_tens,
    output logic [3:0] o_unit,
    output logic       o_blank_h,
    output logic       o_blank_t,
    output logic       o_sign
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_last;
    logic [19:0] r_sr;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_unit;
    logic        r_blank_h;
    logic        r_blank_t;
    logic [7:0]  w_mag;
    logic [19:0] w_corr;
    logic [19:0] w_shift;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Add-3 correction on the three BCD nibbles, then a 1-bit left shift.
    assign w_corr  = {add3(r_sr[19:16]), add3(r_sr[15:12]), add3(r_sr[11:8]), r_sr[7:0]};
    assign w_shift = w_corr << 1;

`ifdef SIGNED_EN
    logic r_sign_cap;
    logic r_sign;

    // 8'h80 negates to itself, which read unsigned is the correct magnitude 128.
    assign w_mag  = i_value[7] ? (~i_value + 8'd1) : i_value;
    assign o_sign = r_sign;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sign_cap <= 1'b0;
            r_sign     <= 1'b0;
        end else begin
            if (w_accept)
                r_sign_cap <= i_value[7];
            if (w_last)
                r_sign <= r_sign_cap;
        end
    end
`else
    assign w_mag  = i_value;
    assign o_sign = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = i_start;
                w_next   = i_start ? S_SHIFT : S_IDLE;
            end
            S_SHIFT: begin
                w_last = (r_cnt == 3'd7);
                w_next = w_last ? S_FIN : S_SHIFT;
            end
            S_FIN: begin
                w_accept = i_start;
                w_next   = i_start ? S_SHIFT : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hund    <= '0;
            r_tens    <= '0;
            r_unit    <= '0;
            r_blank_h <= 1'b1;
            r_blank_t <= 1'b1;
        end else begin
            // Status flags are registered from the next state so they line up with it.
            r_busy <= (w_next == S_SHIFT);
            r_done <= (w_next == S_FIN);
            if (w_accept) begin
                r_sr  <= {12'd0, w_mag};
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_sr  <= w_shift;
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_last) begin
                r_hund    <= w_shift[19:16];
                r_tens    <= w_shift[15:12];
                r_unit    <= w_shift[11:8];
                r_blank_h <= (w_shift[19:16] == 4'd0);
                r_blank_t <= (w_shift[19:12] == 8'd0);
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_hund    = r_hund;
    assign o_tens    = r_tens;
    assign o_unit    = r_unit;
    assign o_blank_h = r_blank_h;
    assign o_blank_t = r_blank_t;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq against a decimal-arithmetic reference model
module tb_bin_to_bcd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] value;
    logic       o_busy, o_done, o_blank_h, o_blank_t, o_sign;
    logic [3:0] o_hund, o_tens, o_unit;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    // Reference model: conversion result by division, timing by a countdown of clocks.
    int  m_cnt = 0;
    int  m_mag = 0;
    bit  m_neg = 1'b0;
    bit  m_busy, m_done, m_bh, m_bt, m_sign;
    int  m_h, m_t, m_u;

    bin_to_bcd_seq dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_value(value),
        .o_busy(o_busy), .o_done(o_done), .o_hund(o_hund), .o_tens(o_tens),
        .o_unit(o_unit), .o_blank_h(o_blank_h), .o_blank_t(o_blank_t), .o_sign(o_sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_busy = 0; m_done = 0;
            m_h = 0; m_t = 0; m_u = 0; m_bh = 1; m_bt = 1; m_sign = 0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            m_busy = (m_cnt != 0);
            m_done = (m_cnt == 0);
            if (m_cnt == 0) begin
                m_h = m_mag / 100;
                m_t = (m_mag / 10) % 10;
                m_u = m_mag % 10;
                m_bh = (m_h == 0);
                m_bt = (m_h == 0 && m_t == 0);
                m_sign = m_neg;
            end
        end else begin
            m_done = 0;
            if (start) begin
`ifdef SIGNED_EN
                m_neg = value[7];
                m_mag = value[7] ? 256 - int'(value) : int'(value);
`else
                m_neg = 0;
                m_mag = int'(value);
`endif
                m_cnt = 8;
                m_busy = 1;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("busy", o_busy, m_busy);
            check("done", o_done, m_done);
            check("hund", o_hund, m_h[7:0]);
            check("tens", o_tens, m_t[7:0]);
            check("unit", o_unit, m_u[7:0]);
            check("blank_h", o_blank_h, m_bh);
            check("blank_t", o_blank_t, m_bt);
            check("sign", o_sign, m_sign);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!o_done && n < 40);
        if (!o_done) check("done_timeout", 8'd0, 8'd1);
    endtask

    task automatic convert(input logic [7:0] v, output int n);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
    endtask

    task automatic expect_out(input string name, input logic [3:0] h, input logic [3:0] t,
                              input logic [3:0] u, input logic bh, input logic bt, input logic sg);
        check({name, "_hund"}, o_hund, h);
        check({name, "_tens"}, o_tens, t);
        check({name, "_unit"}, o_unit, u);
        check({name, "_blank_h"}, o_blank_h, bh);
        check({name, "_blank_t"}, o_blank_t, bt);
        check({name, "_sign"}, o_sign, sg);
    endtask

    initial begin
        int n;
        int n2;
        rst = 1'b1; start = 1'b0; value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        expect_out("rst", 0, 0, 0, 1, 1, 0);

`ifndef SIGNED_EN
        convert(8'd255, n);
        check("lat255", n[7:0], 8'd8);
        expect_out("v255", 2, 5, 5, 0, 0, 0);
        convert(8'd7, n);
        expect_out("v7", 0, 0, 7, 1, 1, 0);
        convert(8'd40, n);
        expect_out("v40", 0, 4, 0, 1, 0, 0);
`else
        convert(8'h80, n);
        check("lat80", n[7:0], 8'd8);
        expect_out("s80", 1, 2, 8, 0, 0, 1);
        convert(8'hFF, n);
        expect_out("sFF", 0, 0, 1, 1, 1, 1);
        convert(8'h7F, n);
        expect_out("s7F", 1, 2, 7, 0, 0, 0);
`endif

        @(negedge clk);
        value = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        value = 8'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        expect_out("v100", 1, 0, 0, 0, 0, 0);
        value = 8'd99; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(n2);
        check("b2b_gap", 8'(n2 + 1), 8'd9);
        expect_out("v99", 0, 9, 9, 1, 0, 0);

        @(negedge clk);
        value = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        expect_out("abort", 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #2;
            check("no_done", o_done, 1'b0);
        end
        convert(8'd1, n);
        expect_out("v1", 0, 0, 1, 1, 1, 0);

        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            value = 8'($urandom);
            rst = ($urandom_range(499) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
